// File: rtl/sdram_req_arb_if.sv
// -----------------------------------------------------------------------------
// sdram_req_arb_if
// Bundles both request ports (A = CPU, B = display/DMA), the sdram_ctl host
// interface and the arbiter status flags.
//   slave  : arbiter side (takes requests, drives acks/rdata/ctl_*/status)
//   master : environment side (drives requests and the controller responses)
// Signals:
//   a_req/a_we/a_addr/a_wdata, a_ack/a_rdata   port A request / completion
//   b_req/b_we/b_addr/b_wdata, b_ack/b_rdata   port B request / completion
//   ctl_addr/ctl_data_in/ctl_write_en/ctl_refresh_data/ctl_burst_en
//                                              command towards sdram_ctl
//   ctl_data_ready/ctl_data_out                status/data from sdram_ctl
//   busy/err                                   arbiter status
// -----------------------------------------------------------------------------
interface sdram_req_arb_if #(
    parameter int ADDR_W = 25,
    parameter int DATA_W = 16
);
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_ack;
    logic [DATA_W-1:0] a_rdata;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_ack;
    logic [DATA_W-1:0] b_rdata;

    logic [ADDR_W-1:0] ctl_addr;
    logic [DATA_W-1:0] ctl_data_in;
    logic              ctl_write_en;
    logic              ctl_refresh_data;
    logic              ctl_burst_en;
    logic              ctl_data_ready;
    logic [DATA_W-1:0] ctl_data_out;

    logic              busy;
    logic              err;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_ack, a_rdata,
        input  b_req, b_we, b_addr, b_wdata,
        output b_ack, b_rdata,
        output ctl_addr, ctl_data_in, ctl_write_en, ctl_refresh_data, ctl_burst_en,
        input  ctl_data_ready, ctl_data_out,
        output busy, err
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_ack, a_rdata,
        output b_req, b_we, b_addr, b_wdata,
        input  b_ack, b_rdata,
        input  ctl_addr, ctl_data_in, ctl_write_en, ctl_refresh_data, ctl_burst_en,
        output ctl_data_ready, ctl_data_out,
        input  busy, err
    );
endinterface

// File: rtl/sdram_req_arb.sv
// -----------------------------------------------------------------------------
// sdram_req_arb
// Two-port round-robin request arbiter in front of sdram_ctl. Serialises
// single-word reads/writes from port A and port B onto the controller host
// interface, one access outstanding at a time, with a one-cycle ack per access
// and read data returned on the granted port. A cycle counter abandons an
// access that hangs in ISSUE/BUSY and raises a sticky err flag.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-low reset
//   bus  : sdram_req_arb_if.slave (request ports, ctl_* interface, busy, err)
// All outputs are registered.
// -----------------------------------------------------------------------------
module sdram_req_arb #(
    parameter int ADDR_W  = 25,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic           clk,
    input  logic           rst,
    sdram_req_arb_if.slave bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    // Count value in the last cycle before the counter would reach TIMEOUT.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_BUSY  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic              w_grant;
    logic              w_grant_b;
    logic              w_complete;
    logic              w_timeout;

    logic              r_last_b;     // 1 = port B was granted last
    logic              r_gnt_b;      // port owning the current access
    logic [CNT_W-1:0]  r_cnt;

    logic [ADDR_W-1:0] r_ctl_addr;
    logic [DATA_W-1:0] r_ctl_data_in;
    logic              r_ctl_write_en;
    logic              r_ctl_refresh;
    logic              r_a_ack;
    logic              r_b_ack;
    logic [DATA_W-1:0] r_a_rdata;
    logic [DATA_W-1:0] r_b_rdata;
    logic              r_busy;
    logic              r_err;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and arbitration decode
    always_comb begin
        w_next     = r_state;
        w_grant    = 1'b0;
        w_grant_b  = 1'b0;
        w_complete = 1'b0;
        w_timeout  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.ctl_data_ready && (bus.a_req || bus.b_req)) begin
                    w_grant   = 1'b1;
                    // B wins when alone, or on a tie when A was served last.
                    w_grant_b = bus.b_req && (!bus.a_req || !r_last_b);
                    w_next    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Timeout is checked first so the counter can never run past
                // CNT_LAST by slipping into BUSY on the same cycle.
                if (r_cnt == CNT_LAST) begin
                    w_timeout = 1'b1;
                    w_next    = S_DONE;
                end else if (!bus.ctl_data_ready) begin
                    w_next = S_BUSY;
                end
            end
            S_BUSY: begin
                // A controller that finishes on the last allowed cycle still
                // counts as a real completion.
                if (bus.ctl_data_ready) begin
                    w_complete = 1'b1;
                    w_next     = S_DONE;
                end else if (r_cnt == CNT_LAST) begin
                    w_timeout = 1'b1;
                    w_next    = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Registered outputs, grant bookkeeping and timeout counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_last_b       <= 1'b1;
            r_gnt_b        <= 1'b0;
            r_cnt          <= '0;
            r_ctl_addr     <= '0;
            r_ctl_data_in  <= '0;
            r_ctl_write_en <= 1'b0;
            r_ctl_refresh  <= 1'b0;
            r_a_ack        <= 1'b0;
            r_b_ack        <= 1'b0;
            r_a_rdata      <= '0;
            r_b_rdata      <= '0;
            r_busy         <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            r_a_ack <= 1'b0;
            r_b_ack <= 1'b0;
            r_busy  <= (w_next != S_IDLE);

            if (r_state == S_ISSUE || r_state == S_BUSY) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_grant) begin
                r_gnt_b        <= w_grant_b;
                r_last_b       <= w_grant_b;
                r_cnt          <= '0;
                r_ctl_refresh  <= 1'b1;
                r_ctl_addr     <= w_grant_b ? bus.b_addr  : bus.a_addr;
                r_ctl_write_en <= w_grant_b ? bus.b_we    : bus.a_we;
                r_ctl_data_in  <= w_grant_b ? bus.b_wdata : bus.a_wdata;
            end

            if (w_complete) begin
                r_ctl_refresh <= 1'b0;
                if (!r_ctl_write_en) begin
                    if (r_gnt_b) r_b_rdata <= bus.ctl_data_out;
                    else         r_a_rdata <= bus.ctl_data_out;
                end
            end

            if (w_timeout) begin
                r_ctl_refresh <= 1'b0;
                r_err         <= 1'b1;
            end

            if (w_complete || w_timeout) begin
                r_a_ack <= !r_gnt_b;
                r_b_ack <= r_gnt_b;
            end
        end
    end

    assign bus.a_ack            = r_a_ack;
    assign bus.a_rdata          = r_a_rdata;
    assign bus.b_ack            = r_b_ack;
    assign bus.b_rdata          = r_b_rdata;
    assign bus.ctl_addr         = r_ctl_addr;
    assign bus.ctl_data_in      = r_ctl_data_in;
    assign bus.ctl_write_en     = r_ctl_write_en;
    assign bus.ctl_refresh_data = r_ctl_refresh;
    assign bus.ctl_burst_en     = 1'b0;
    assign bus.busy             = r_busy;
    assign bus.err              = r_err;

endmodule

// File: tb/tb_sdram_req_arb.sv
// -----------------------------------------------------------------------------
// tb_sdram_req_arb
// Directed bench for sdram_req_arb (TIMEOUT=8) with a small sdram_ctl model:
//   mode 0: drops data_ready one cycle after refresh_data, raises it 5 cycles
//           later and performs the access on a 16-word memory
//   mode 1: never drops data_ready (access hangs -> timeout)
//   mode 2: holds data_ready low (controller busy)
// -----------------------------------------------------------------------------
module tb_sdram_req_arb;

    localparam int ADDR_W = 25;
    localparam int DATA_W = 16;

    logic clk;
    logic rst;

    sdram_req_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sdram_req_arb #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // ---------------- controller model ----------------
    logic [DATA_W-1:0] mem [16];
    int                mode;
    int                mst;
    int                mcnt;
    logic [3:0]        m_addr;
    logic              m_we;
    logic [DATA_W-1:0] m_data;

    always @(posedge clk) begin
        if (mode == 0) begin
            case (mst)
                0: begin
                    if (bus.ctl_refresh_data) begin
                        bus.ctl_data_ready <= 1'b0;
                        m_addr <= bus.ctl_addr[3:0];
                        m_we   <= bus.ctl_write_en;
                        m_data <= bus.ctl_data_in;
                        mcnt   <= 0;
                        mst    <= 1;
                    end else begin
                        bus.ctl_data_ready <= 1'b1;
                    end
                end
                1: begin
                    mcnt <= mcnt + 1;
                    if (mcnt == 4) begin
                        bus.ctl_data_ready <= 1'b1;
                        if (m_we) mem[m_addr] <= m_data;
                        else      bus.ctl_data_out <= mem[m_addr];
                        mst <= 2;
                    end
                end
                default: begin
                    if (!bus.ctl_refresh_data) mst <= 0;
                end
            endcase
        end else if (mode == 1) begin
            bus.ctl_data_ready <= 1'b1;
            mst <= 0;
        end else begin
            bus.ctl_data_ready <= 1'b0;
            mst <= 0;
        end
    end

    // ---------------- ack monitor ----------------
    int         a_acks = 0;
    int         b_acks = 0;
    int         both_acks = 0;
    logic [7:0] order = '0;   // shift register of acked ports, 1 = B

    always @(negedge clk) begin
        if (rst) begin
            if (bus.a_ack && bus.b_ack) both_acks++;
            if (bus.a_ack) begin
                a_acks++;
                order = {order[6:0], 1'b0};
            end
            if (bus.b_ack) begin
                b_acks++;
                order = {order[6:0], 1'b1};
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until the chosen port acks; n = edges taken.
    task automatic wait_ack(input string tag, input bit port_b, input int budget, output int n);
        logic got;
        got = 1'b0;
        n   = 0;
        while (!got && n < budget) begin
            tick();
            n++;
            got = port_b ? bus.b_ack : bus.a_ack;
        end
        if (!got) check_eq({tag, "_ack_seen"}, {31'd0, got}, 32'd1);
    endtask

    int n;
    int a0, b0;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = DATA_W'(16'h1111 * i);
        mode = 0;
        mst  = 0;
        mcnt = 0;
        bus.ctl_data_ready = 1'b1;
        bus.ctl_data_out   = '0;
        bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
        bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;

        // Reset with a pending A write
        rst = 1'b0;
        bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = '0; bus.a_wdata = 16'h00ff;
        tick();
        tick();
        check_eq("rst_a_ack",   {31'd0, bus.a_ack}, 32'd0);
        check_eq("rst_refresh", {31'd0, bus.ctl_refresh_data}, 32'd0);
        check_eq("rst_err",     {31'd0, bus.err}, 32'd0);
        check_eq("rst_busy",    {31'd0, bus.busy}, 32'd0);
        check_eq("rst_a_rdata", 32'(bus.a_rdata), 32'd0);
        check_eq("rst_burst",   {31'd0, bus.ctl_burst_en}, 32'd0);

        // Release: grant A on the first edge, write 00ff to address 0
        rst = 1'b1;
        tick();
        check_eq("wr_refresh", {31'd0, bus.ctl_refresh_data}, 32'd1);
        check_eq("wr_busy",    {31'd0, bus.busy}, 32'd1);
        check_eq("wr_addr",    32'(bus.ctl_addr), 32'd0);
        check_eq("wr_we",      {31'd0, bus.ctl_write_en}, 32'd1);
        check_eq("wr_data",    32'(bus.ctl_data_in), 32'h00ff);
        wait_ack("wr", 1'b0, 20, n);
        check_eq("wr_latency", 32'(n), 32'd7);
        check_eq("wr_done_refresh", {31'd0, bus.ctl_refresh_data}, 32'd0);
        check_eq("wr_data_hold", 32'(bus.ctl_data_in), 32'h00ff);
        bus.a_req = 1'b0;
        tick();
        check_eq("wr_ack_pulse", {31'd0, bus.a_ack}, 32'd0);
        tick();
        check_eq("wr_mem0", 32'(mem[0]), 32'h00ff);
        check_eq("wr_a_acks", 32'(a_acks), 32'd1);

        // Read-back on port B
        a0 = a_acks;
        bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = '0;
        wait_ack("rd", 1'b1, 30, n);
        bus.b_req = 1'b0;
        check_eq("rd_b_rdata", 32'(bus.b_rdata), 32'h00ff);
        check_eq("rd_a_rdata", 32'(bus.a_rdata), 32'd0);
        tick();
        tick();
        check_eq("rd_b_acks", 32'(b_acks), 32'd1);
        check_eq("rd_no_a_ack", 32'(a_acks - a0), 32'd0);

        // Contention after a fresh reset: A reads 1, B reads 2, held high
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check_eq("rst2_b_rdata", 32'(bus.b_rdata), 32'd0);
        a0 = a_acks; b0 = b_acks; order = '0;
        bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 25'd1;
        bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 25'd2;
        n = 0;
        while ((a_acks + b_acks - a0 - b0) < 4 && n < 100) begin
            tick();
            n++;
        end
        bus.a_req = 1'b0; bus.b_req = 1'b0;
        check_eq("ct_count", 32'(a_acks + b_acks - a0 - b0), 32'd4);
        check_eq("ct_order", {28'd0, order[3:0]}, 32'b0101);
        check_eq("ct_a_rdata", 32'(bus.a_rdata), 32'h1111);
        check_eq("ct_b_rdata", 32'(bus.b_rdata), 32'h2222);
        tick();
        tick();
        tick();

        // Controller busy: ready held low, A read of address 3 must wait
        mode = 2;
        tick();
        tick();
        bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 25'd3;
        for (int i = 0; i < 5; i++) tick();
        check_eq("cb_refresh", {31'd0, bus.ctl_refresh_data}, 32'd0);
        check_eq("cb_busy",    {31'd0, bus.busy}, 32'd0);
        mode = 0;
        tick();
        tick();
        check_eq("cb_grant", {31'd0, bus.ctl_refresh_data}, 32'd1);
        wait_ack("cb", 1'b0, 20, n);
        bus.a_req = 1'b0;
        check_eq("cb_a_rdata", 32'(bus.a_rdata), 32'h3333);
        tick();
        tick();

        // Timeout: model never drops ready
        mode = 1;
        bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 25'd5;
        tick();
        check_eq("to_grant", {31'd0, bus.ctl_refresh_data}, 32'd1);
        wait_ack("to", 1'b0, 20, n);
        bus.a_req = 1'b0;
        check_eq("to_latency", 32'(n), 32'd8);
        check_eq("to_err",     {31'd0, bus.err}, 32'd1);
        check_eq("to_refresh", {31'd0, bus.ctl_refresh_data}, 32'd0);
        check_eq("to_a_rdata", 32'(bus.a_rdata), 32'h3333);
        tick();
        tick();
        tick();
        check_eq("to_err_sticky", {31'd0, bus.err}, 32'd1);

        // Next request proceeds normally, err stays set
        mode = 0;
        tick();
        b0 = b_acks;
        bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 25'd4;
        wait_ack("post", 1'b1, 30, n);
        bus.b_req = 1'b0;
        check_eq("post_b_rdata", 32'(bus.b_rdata), 32'h4444);
        check_eq("post_err",     {31'd0, bus.err}, 32'd1);
        tick();
        tick();

        // Reset clears err
        rst = 1'b0;
        tick();
        check_eq("rst3_err", {31'd0, bus.err}, 32'd0);
        rst = 1'b1;
        tick();
        check_eq("both_acks_never", 32'(both_acks), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sdram_req_arb.md
Name: sdram_req_arb

Overview:
Two-port request arbiter directly upstream of sdram_ctl. It takes single-word read/write requests from port A (CPU) and port B (display/DMA) and serialises them onto the sdram_ctl host interface (addr, data_in, write_en, refresh_data, data_ready, data_out). Only one access is outstanding at a time. Arbitration is round-robin. Each port gets a one-cycle ack, and reads also return data.

Parameters:
ADDR_W, 25, word address width (matches sdram_ctl addr)
DATA_W, 16, data width (matches sdram_ctl data_in/data_out)
TIMEOUT, 1023, max cycles spent in ISSUE+BUSY before the access is abandoned; counter width = clog2(TIMEOUT+1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-low reset
a_req  in  1  port A request, held until a_ack
a_we  in  1  port A 1=write 0=read, stable while a_req
a_addr  in  ADDR_W  port A word address
a_wdata  in  DATA_W  port A write data
a_ack  out  1  one-cycle completion pulse for port A
a_rdata  out  DATA_W  port A read data, valid from a_ack, held until next A read
b_req, b_we, b_addr, b_wdata, b_ack, b_rdata  same as port A, for port B
ctl_addr  out  ADDR_W  to sdram_ctl addr
ctl_data_in  out  DATA_W  to sdram_ctl data_in
ctl_write_en  out  1  to sdram_ctl write_en
ctl_refresh_data  out  1  to sdram_ctl refresh_data; 1 requests an access
ctl_burst_en  out  1  to sdram_ctl burst_en; constant 0
ctl_data_ready  in  1  from sdram_ctl data_ready; 1 = idle, last access complete
ctl_data_out  in  DATA_W  from sdram_ctl data_out
busy  out  1  1 in any state other than IDLE
err  out  1  sticky timeout flag

Behaviour:
- Reset (rst=0 at a clock edge): state=IDLE; all outputs 0, including a_rdata/b_rdata, ctl_* and err; last_grant=B, so A wins the first tie; timeout counter=0.
- Reset mid-access abandons the access: ctl_refresh_data drops to 0 on that edge and no ack is issued.
- All outputs are registered. No combinational path from an input to an output.
- States: IDLE, ISSUE, BUSY, DONE.
- IDLE:
  - Sample requests only when ctl_data_ready=1.
  - Grant: the sole requester; if both request, the port not granted last. Record grant in last_grant.
  - On grant: latch the port's addr/we/wdata into ctl_addr/ctl_write_en/ctl_data_in, set ctl_refresh_data=1, clear the counter, go ISSUE.
  - With no request, or ctl_data_ready=0, stay in IDLE.
- ISSUE: hold ctl_* stable. On ctl_data_ready=0 (controller accepted), go BUSY.
- BUSY:
  - On ctl_data_ready=1: set ctl_refresh_data=0.
  - If the access was a read, capture ctl_data_out into the granted port's rdata.
  - Pulse the granted port's ack. Go DONE.
- DONE: ack is high for exactly this cycle; go IDLE. A requester sees ack at the edge leaving DONE and updates req at that same edge, so IDLE samples the new req value. Minimum request-to-ack latency = 1 (IDLE) + 1 (ISSUE) + 1 (BUSY) = ack in 4th cycle after req, plus the controller's own latency.
- Timeout:
  - The counter increments every cycle in ISSUE or BUSY.
  - When it reaches TIMEOUT: set err=1 (sticky until reset), set ctl_refresh_data=0, pulse ack to the granted port with rdata unchanged, go DONE.
- Ports not granted see no ack. Their req/addr changes during an access are ignored.
- ack is never asserted for both ports in the same cycle.
- a_req or b_req deasserted before ack while not granted is legal (request withdrawn). Deasserting a granted req has no effect; the access completes and acks.
- ctl_write_en and ctl_data_in keep their last values in IDLE; only ctl_refresh_data qualifies them.

Test Plan:
- Reset: hold rst=0 for 2 cycles with a_req=1 -> a_ack=0, ctl_refresh_data=0, err=0, busy=0. Release rst -> grant A on the first cycle with ctl_data_ready=1.
- Single write: a_req=1, a_we=1, a_addr=0, a_wdata=16'h00ff; controller model drops ready 1 cycle after refresh_data, raises it 5 cycles later -> ctl_addr=0, ctl_write_en=1, ctl_data_in=16'h00ff throughout; one a_ack pulse; sdram mem[0]=16'h00ff.
- Read-back: b_req=1, b_we=0, b_addr=0 after the write above -> b_ack pulses once; b_rdata=16'h00ff; a_rdata unchanged.
- Contention: a_req and b_req held continuously with addresses 1 and 2 -> grants alternate A,B,A,B (start A after reset); exactly one ack per access; never both acks in one cycle.
- Controller busy: ctl_data_ready=0 while in IDLE with a_req=1 -> stays IDLE, ctl_refresh_data=0 until ready=1, then grants.
- Timeout: TIMEOUT=8, model never drops ready after refresh_data -> a_ack pulses 8 cycles after ISSUE entry; err=1 and stays 1; the next request proceeds normally; rst=0 clears err.
